// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader
// (imem_loader and imem_word_assembler). Optional feature macro: IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int unsigned IMEM_DEPTH      = 256;
  localparam int unsigned IMEM_WORD_W     = 32;
  localparam int unsigned WORD_ADDR_SHIFT = 2;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  // PC-style byte address of a word slot; wraps modulo 2^32.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [31:0] index);
    return base + (index << WORD_ADDR_SHIFT);
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word packer: emits a one-cycle word_valid the cycle after
// the 4th byte of a word. clear discards any partially assembled word.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic [IMEM_WORD_W-1:0] word,
  output logic                   word_valid
);

  logic [1:0]               byte_cnt;
  logic [IMEM_WORD_W-9:0]   partial;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt   <= '0;
      partial    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      byte_cnt   <= '0;
      partial    <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        if (byte_cnt == 2'd3) begin
          word       <= {partial, byte_data};
          word_valid <= 1'b1;
          byte_cnt   <= '0;
        end else begin
          partial  <= {partial[IMEM_WORD_W-17:0], byte_data};
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: header(2B count) + big-endian words, holds the CPU
// until the image is complete. Define IMEM_LOADER_CHECKSUM_EN to require an XOR trailer byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = IMEM_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int unsigned IDX_W   = $clog2(DEPTH) + 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  loader_state_t          state;
  logic [15:0]            count;
  logic [IDX_W-1:0]       index;
  logic                   xfer;
  logic                   start_ok;
  logic                   last_word;
  logic                   final_write;
  logic                   asm_strobe;
  logic                   asm_valid;
  logic [IMEM_WORD_W-1:0] asm_word;
  logic [31:0]            next_index;
  logic [31:0]            hdr_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]             csum;
`endif

  assign xfer        = in_valid & in_ready;
  assign start_ok    = start && (state == IDLE || state == DONE || state == ERR);
  assign next_index  = 32'(index) + 32'd1;
  assign last_word   = (next_index == {16'd0, count});
  assign final_write = asm_valid && last_word;
  // A byte arriving during the last word's write cycle is never data: it is the
  // trailer when checksums are enabled, otherwise surplus and dropped.
  assign asm_strobe  = xfer && (state == DATA) && !final_write;
  assign hdr_count   = {16'd0, count[15:8], in_data};

  assign wr_en   = asm_valid;
  assign wr_data = asm_word;

  imem_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_valid (asm_strobe),
    .byte_data  (in_data),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      wr_addr  <= BASE_ADDR;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      count    <= '0;
      index    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start_ok) begin
            state    <= HDR_HI;
            in_ready <= 1'b1;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
            index    <= '0;
            wr_addr  <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end else if (state == DONE) begin
            cpu_hold <= 1'b0;
          end
        end

        HDR_HI: begin
          if (xfer) begin
            count[15:8] <= in_data;
            state       <= HDR_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum        <= csum ^ in_data;
`endif
          end
        end

        HDR_LO: begin
          if (xfer) begin
            count[7:0] <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= csum ^ in_data;
`endif
            if (hdr_count > DEPTH_W) begin
              state    <= ERR;
              err      <= 1'b1;
              in_ready <= 1'b0;
            end else if (hdr_count == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= CHK;
`else
              state    <= DONE;
              done     <= 1'b1;
              in_ready <= 1'b0;
`endif
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (asm_strobe) csum <= csum ^ in_data;
`endif
          if (asm_valid) begin
            index   <= index + IDX_W'(1);
            wr_addr <= word_byte_addr(BASE_ADDR, next_index);
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              if (!xfer) begin
                state <= CHK;
              end else if (in_data == csum) begin
                state    <= DONE;
                done     <= 1'b1;
                in_ready <= 1'b0;
              end else begin
                state    <= ERR;
                err      <= 1'b1;
                in_ready <= 1'b0;
              end
`else
              state    <= DONE;
              done     <= 1'b1;
              in_ready <= 1'b0;
`endif
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a stream-level model predicts the write sequence,
// a per-cycle compare process checks writes/done/cpu_hold; directed loads cover the edge cases.
module tb_imem_loader;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned LIMIT = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int unsigned LAT_DATA = 0;
`else
  localparam int unsigned LAT_DATA = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, wr_en, cpu_hold, done, err;
  logic [31:0] wr_addr, wr_data;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  stream[$];
  int unsigned wr_seen   = 0;
  int unsigned done_seen = 0;
  logic        done_allowed = 1'b0;
  logic        hold_exp;
  logic        checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // cpu_hold must be high from reset/start until the cycle after the done pulse.
  always @(posedge clk) begin
    if (rst || start) hold_exp <= 1'b1;
    else if (done)    hold_exp <= 1'b0;
  end

  always @(negedge clk) begin
    if (checking) begin
      logic [63:0] e;
      check("cpu_hold", {31'd0, cpu_hold}, {31'd0, hold_exp});
      check("wr_addr_aligned", {30'd0, wr_addr[1:0]}, 32'd0);
      if (err) check("in_ready_in_err", {31'd0, in_ready}, 32'd0);
      if (wr_en) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_wr_en", {31'd0, wr_en}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e[63:32]);
          check("wr_data", wr_data, e[31:0]);
        end
      end
      if (done) begin
        done_seen++;
        check("done_allowed", {31'd0, done_allowed}, 32'd1);
        check("writes_before_done", exp_q.size(), 32'd0);
        done_allowed = 1'b0;
      end
    end
  end

  task automatic build_model(output int unsigned nwords);
    logic [15:0] hdr;
    hdr = {stream[0], stream[1]};
    exp_q.delete();
    wr_seen   = 0;
    done_seen = 0;
    nwords       = (hdr > DEPTH) ? 0 : int'(hdr);
    done_allowed = (hdr <= DEPTH);
    for (int unsigned i = 0; i < nwords; i++)
      exp_q.push_back({BASE + 32'(4 * i), stream[2+4*i], stream[3+4*i],
                       stream[4+4*i], stream[5+4*i]});
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (hdr <= DEPTH) begin
      logic [7:0] x;
      x = '0;
      foreach (stream[k]) x ^= stream[k];
      stream.push_back(x);
    end
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap, input bit poke_start);
    int unsigned guard;
    guard = 0;
    start = poke_start;
    repeat (gap) begin
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    if (guard == LIMIT) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_bytes(input int unsigned n, input int unsigned gap, input int poke_at);
    for (int unsigned i = 0; i < n; i++)
      send_byte(stream[i], gap, (int'(i) == poke_at));
  endtask

  task automatic wait_done(input int unsigned exp_lat);
    int unsigned n;
    n = 0;
    while (!done && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", n, exp_lat);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("cpu_hold_released", {31'd0, cpu_hold}, 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_wr_en",    {31'd0, wr_en},    32'd0);
    check("rst_wr_addr",  wr_addr,           BASE);
    check("rst_wr_data",  wr_data,           32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_err",      {31'd0, err},      32'd0);
  endtask

  task automatic full_load(input int unsigned gap, input int poke_at);
    int unsigned nw;
    build_model(nw);
    pulse_start();
    send_bytes(stream.size(), gap, poke_at);
    wait_done(nw == 0 ? 0 : LAT_DATA);
    check("wr_count", wr_seen, nw);
    check("done_count", done_seen, 32'd1);
  endtask

  initial begin
    logic [63:0] e;
    int unsigned nw;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values();
    checking = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    // Two-word image at full rate, with the model pinned to hand values.
    stream = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01, 8'h20, 8'h21, 8'h00, 8'h05};
    build_model(nw);
    e = exp_q[0];
    check("model_w0_addr", e[63:32], 32'h0000_0000);
    check("model_w0_data", e[31:0],  32'h3C01_0001);
    e = exp_q[1];
    check("model_w1_addr", e[63:32], 32'h0000_0004);
    check("model_w1_data", e[31:0],  32'h2021_0005);
    full_load(0, -1);

    // Empty image.
    stream = '{8'h00, 8'h00};
    full_load(0, -1);

    // Oversized header: error, no writes, sticky until start.
    stream = '{8'h01, 8'h01};
    build_model(nw);
    pulse_start();
    send_bytes(2, 0, -1);
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (4) @(negedge clk);
    check("ovf_err_sticky", {31'd0, err}, 32'd1);
    check("ovf_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("ovf_wr_count", wr_seen, 32'd0);
    check("ovf_done_count", done_seen, 32'd0);
    pulse_start();
    check("ovf_err_cleared", {31'd0, err}, 32'd0);
    stream = '{8'h00, 8'h00};
    build_model(nw);
    send_bytes(stream.size(), 0, -1);
    wait_done(0);

    // Throttled stream plus a stray start mid-word: identical result.
    stream = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01, 8'h20, 8'h21, 8'h00, 8'h05};
    full_load(1, 5);

    // Reset after six data bytes: one write already done, nothing after.
    stream = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01, 8'h20, 8'h21, 8'h00, 8'h05};
    build_model(nw);
    pulse_start();
    send_bytes(8, 0, -1);
    rst = 1'b1;
    exp_q.delete();
    done_allowed = 1'b0;
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_wr_count", wr_seen, 32'd1);
    stream = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01, 8'h20, 8'h21, 8'h00, 8'h05};
    full_load(0, -1);

    // Maximum image: count == DEPTH is accepted.
    stream = '{8'h01, 8'h00};
    for (int unsigned i = 0; i < 4 * DEPTH; i++) stream.push_back(8'((i * 7 + 3) & 32'hFF));
    build_model(nw);
    e = exp_q[DEPTH-1];
    check("model_last_addr", e[63:32], 32'h0000_03FC);
    check("model_nwords", nw, DEPTH);
    stream = stream[0:$];
    pulse_start();
    send_bytes(stream.size(), 0, -1);
    wait_done(LAT_DATA);
    check("max_wr_count", wr_seen, DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum trailer: match then mismatch.
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    build_model(nw);
    check("model_trailer", {24'd0, stream[6]}, 32'h09);
    pulse_start();
    send_bytes(stream.size(), 0, -1);
    wait_done(0);
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    build_model(nw);
    stream[6] = 8'h00;
    done_allowed = 1'b0;
    pulse_start();
    send_bytes(stream.size(), 0, -1);
    repeat (2) @(negedge clk);
    check("csum_err", {31'd0, err}, 32'd1);
    check("csum_wr_count", wr_seen, 32'd1);
    check("csum_cpu_hold", {31'd0, cpu_hold}, 32'd1);
`endif

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
